lsu: RTL and testbench
======================

# lsu

Load/store unit sitting directly downstream of the control unit in the NPC core. It latches a retiring instruction's memory request (store flag, byte mask, address, data; or load flag and size mask), performs it over an AXI4-Lite-style master interface to a multi-cycle memory, and returns aligned load data to the control unit's sign-extension logic. It holds the core in-order by deasserting `in_ready` while a transaction is outstanding.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: bus data width (fixed 32; byte strobes are 4 bits).

- `clk`  in  1  core clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request from control unit valid.
- `in_ready`  out  1  high only in IDLE.
- `in_store`  in  1  store request (CU `reg_to_mem`).
- `in_load`  in  1  load request (CU `mem_to_reg`).
- `in_addr`  in  32  effective address.
- `in_wdata`  in  32  store data, unshifted (value in low bits).
- `in_wmask`  in  8  store mask: 01/02/04/08 byte, 03/0c half, ff word.
- `in_rmask`  in  8  load size: 01 byte, 02 half, ff word.
- `out_valid`  out  1  result valid; held until `out_ready`.
- `out_ready`  in  1  downstream accepts result.
- `out_rdata`  out  32  load data shifted so the addressed byte/half is at bit 0; 0 for stores/non-memory.
- `out_err`  out  1  misalignment, bad mask, load+store both set, or non-zero bus response.
- `araddr` out 32, `arvalid` out 1, `arready` in 1: read address channel.
- `rdata` in 32, `rresp` in 2, `rvalid` in 1, `rready` out 1: read data channel.
- `awaddr` out 32, `awvalid` out 1, `awready` in 1: write address channel.
- `wdata` out 32, `wstrb` out 4, `wvalid` out 1, `wready` in 1: write data channel.
- `bresp` in 2, `bvalid` in 1, `bready` out 1: write response channel.

## Operation
- States: IDLE, AR, R, W (AW+W phase), B, DONE.
- IDLE: `in_ready`=1. On `in_valid`: latch all inputs. Go to AR if load, W if store, DONE otherwise (non-memory, or error detected at accept).
- Accept-time errors (→ DONE, `out_err`=1, no bus traffic): both `in_load` and `in_store`; half access with addr[0]=1; word access with addr[1:0]≠0; store mask not in the listed set; load mask not 01/02/ff.
- Byte-lane rule: store mask must match addr[1:0] (01@0, 02@1, 04@2, 08@3, 03@0, 0c@2, ff@0); mismatch is an error.
- AR: `arvalid`=1, `araddr`={addr[31:2],2'b00}. On `arready` → R.
- R: `rready`=1. On `rvalid`: capture `rdata >> (8*addr[1:0])`, masked to 8/16/32 bits per `in_rmask`; `out_err`=(`rresp`≠0). → DONE.
- W: `awvalid` and `wvalid` asserted together; each drops independently after its own handshake (internal aw_done/w_done). `wdata`=`in_wdata << (8*addr[1:0])`, `wstrb`=mask[3:0] (ff → 4'hf). When both done → B. Both handshakes in the same cycle → B next cycle.
- B: `bready`=1. On `bvalid`: `out_err`=(`bresp`≠0). → DONE.
- DONE: `out_valid`=1, outputs stable. On `out_ready` → IDLE. Completion is single-cycle; IDLE may accept the next request in the following cycle.
- Latched request and results are never altered by inputs while not in IDLE.

## Timing
- Reset (asynchronous): state=IDLE; `in_ready`=1; `out_valid`, `out_err`, all bus valids/readies = 0; `out_rdata`, `araddr`, `awaddr`, `wdata`, `wstrb` = 0. Reset mid-transaction abandons it immediately, with no handshake completion required.
- Zero-wait memory, accept at cycle 0:
  - Load: AR handshake c1, R handshake c2, `out_valid` c3.
  - Store: AW+W handshake c1, B handshake c2, `out_valid` c3.
  - Non-memory or error: `out_valid` c1.
- Each wait cycle on `arready`/`rvalid`/`awready`/`wready`/`bvalid` adds exactly one cycle.
- Bus valids obey AXI: once asserted, held with stable payload until handshake.
- `rready`/`bready` are asserted only in R/B. A response arriving earlier is not accepted.
- `out_valid` held with `out_ready`=0 keeps all outputs constant indefinitely.

## Test plan
- Word load: addr 0x80000004, rmask ff, memory returns 0xDEADBEEF with 0 waits → `araddr`=0x80000004, `out_rdata`=0xDEADBEEF, `out_err`=0, `out_valid` at c3.
- Byte load: addr 0x80000003, rmask 01, `rdata`=0xA1B2C3D4 → `out_rdata`=0x000000A1. Half load at 0x80000002 → 0x0000A1B2.
- Byte store: addr 0x80000001, wmask 02, data 0x000000EE; `awready` delayed 2 cycles, `wready` immediate → `wdata`=0x0000EE00, `wstrb`=4'b0010, `wvalid` drops after c1, `awvalid` held to c3, `out_valid` at c5.
- Misaligned word load at 0x80000002 → no `arvalid` ever, `out_valid` at c1 with `out_err`=1. Repeat with `bresp`=2'b10 on a legal store → `out_err`=1.
- Backpressure: `out_ready`=0 for 4 cycles in DONE → outputs stable, `in_ready`=0. Then `out_ready`=1 → IDLE next cycle.
- Reset asserted while in R with `rvalid` pending → `rready`/`out_valid` 0 immediately, `in_ready`=1. A fresh load afterwards completes normally.

Source files
------------

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - AXI4-Lite-style memory bus between the load/store unit and memory
interface lsu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;

    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;

    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;

    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output araddr, arvalid, input arready,
        input rdata, rresp, rvalid, output rready,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready
    );

    modport slave (
        input araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input awaddr, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready
    );
endinterface

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: one in-order memory request at a time over an AXI4-Lite-style master
module lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_store,
    input  logic              in_load,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [7:0]        in_wmask,
    input  logic [7:0]        in_rmask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rdata,
    output logic              out_err,
    lsu_if.master             bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_W,
        S_B,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] araddr_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wstrb_q;
    logic [1:0]        lane_q;
    logic [7:0]        rmask_q;
    logic              aw_done;
    logic              w_done;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              acc_err;
    logic              aw_hs;
    logic              w_hs;
    logic [DATA_W-1:0] rshift;
    logic [DATA_W-1:0] rload;

    // Illegal requests are completed locally with an error and never reach the bus.
    always_comb begin
        acc_err = 1'b0;
        if (in_load && in_store) begin
            acc_err = 1'b1;
        end else if (in_load) begin
            case (in_rmask)
                8'h01:   acc_err = 1'b0;
                8'h02:   acc_err = in_addr[0];
                8'hff:   acc_err = |in_addr[1:0];
                default: acc_err = 1'b1;
            endcase
        end else if (in_store) begin
            case (in_wmask)
                8'h01:   acc_err = (in_addr[1:0] != 2'd0);
                8'h02:   acc_err = (in_addr[1:0] != 2'd1);
                8'h04:   acc_err = (in_addr[1:0] != 2'd2);
                8'h08:   acc_err = (in_addr[1:0] != 2'd3);
                8'h03:   acc_err = (in_addr[1:0] != 2'd0);
                8'h0c:   acc_err = (in_addr[1:0] != 2'd2);
                8'hff:   acc_err = (in_addr[1:0] != 2'd0);
                default: acc_err = 1'b1;
            endcase
        end
    end

    assign aw_hs = bus.awvalid && bus.awready;
    assign w_hs  = bus.wvalid && bus.wready;

    assign rshift = bus.rdata >> {lane_q, 3'b000};

    always_comb begin
        case (rmask_q)
            8'h01:   rload = {{(DATA_W-8){1'b0}}, rshift[7:0]};
            8'h02:   rload = {{(DATA_W-16){1'b0}}, rshift[15:0]};
            default: rload = rshift;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    if (acc_err)       state_nx = S_DONE;
                    else if (in_load)  state_nx = S_AR;
                    else if (in_store) state_nx = S_W;
                    else               state_nx = S_DONE;
                end
            end
            S_AR:   if (bus.arready) state_nx = S_R;
            S_R:    if (bus.rvalid)  state_nx = S_DONE;
            // Each channel may complete in any order; B waits for both.
            S_W:    if ((aw_done || aw_hs) && (w_done || w_hs)) state_nx = S_B;
            S_B:    if (bus.bvalid)  state_nx = S_DONE;
            S_DONE: if (out_ready)   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            araddr_q <= '0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            lane_q   <= '0;
            rmask_q  <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        araddr_q <= {in_addr[ADDR_W-1:2], 2'b00};
                        awaddr_q <= {in_addr[ADDR_W-1:2], 2'b00};
                        wdata_q  <= in_wdata << {in_addr[1:0], 3'b000};
                        wstrb_q  <= in_wmask[3:0];
                        lane_q   <= in_addr[1:0];
                        rmask_q  <= in_rmask;
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                        rdata_q  <= '0;
                        err_q    <= acc_err;
                    end
                end
                S_R: begin
                    if (bus.rvalid) begin
                        rdata_q <= rload;
                        err_q   <= (bus.rresp != 2'b00);
                    end
                end
                S_W: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                end
                S_B: begin
                    if (bus.bvalid) err_q <= (bus.bresp != 2'b00);
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (state == S_IDLE);
    assign out_valid   = (state == S_DONE);
    assign out_rdata   = rdata_q;
    assign out_err     = err_q;

    assign bus.araddr  = araddr_q;
    assign bus.arvalid = (state == S_AR);
    assign bus.rready  = (state == S_R);
    assign bus.awaddr  = awaddr_q;
    assign bus.awvalid = (state == S_W) && !aw_done;
    assign bus.wdata   = wdata_q;
    assign bus.wstrb   = wstrb_q;
    assign bus.wvalid  = (state == S_W) && !w_done;
    assign bus.bready  = (state == S_B);
endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for the load/store unit
module tb_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_store, in_load;
    logic [31:0] in_addr, in_wdata;
    logic [7:0]  in_wmask, in_rmask;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_rdata;

    lsu_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    lsu dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_store(in_store), .in_load(in_load),
        .in_addr(in_addr), .in_wdata(in_wdata),
        .in_wmask(in_wmask), .in_rmask(in_rmask),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rdata(out_rdata), .out_err(out_err),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int ar_wait, r_wait, aw_wait, w_wait, b_wait;
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit r_pend, b_pend, aw_got, w_got;
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic [31:0] r_val;
    logic [1:0]  r_resp, b_resp;

    bit          saw_ar;
    logic [31:0] ar_seen, wd_seen;
    logic [3:0]  ws_seen;
    bit          awv [0:63];
    bit          wv  [0:63];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mem_reset();
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
        bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
    endtask

    task automatic set_waits(input int ar, input int r, input int aw, input int w, input int b);
        ar_wait = ar; r_wait = r; aw_wait = aw; w_wait = w; b_wait = b;
    endtask

    // Memory model, evaluated once per negedge; handshakes take effect at the next posedge.
    task automatic drive_mem();
        if (ar_hs) begin r_pend = 1; r_cnt = 0; end
        if (r_hs) r_pend = 0;
        if (aw_hs) aw_got = 1;
        if (w_hs) w_got = 1;
        if (aw_got && w_got) begin b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0; end
        if (b_hs) b_pend = 0;

        bus.arready = bus.arvalid && (ar_cnt >= ar_wait);
        if (bus.arvalid && !bus.arready) ar_cnt++; else ar_cnt = 0;
        bus.awready = bus.awvalid && (aw_cnt >= aw_wait);
        if (bus.awvalid && !bus.awready) aw_cnt++; else aw_cnt = 0;
        bus.wready = bus.wvalid && (w_cnt >= w_wait);
        if (bus.wvalid && !bus.wready) w_cnt++; else w_cnt = 0;

        bus.rvalid = r_pend && (r_cnt >= r_wait);
        if (r_pend && !bus.rvalid) r_cnt++;
        bus.rdata = bus.rvalid ? r_val : 32'h0;
        bus.rresp = bus.rvalid ? r_resp : 2'b00;
        bus.bvalid = b_pend && (b_cnt >= b_wait);
        if (b_pend && !bus.bvalid) b_cnt++;
        bus.bresp = bus.bvalid ? b_resp : 2'b00;

        ar_hs = bus.arvalid && bus.arready;
        r_hs  = bus.rvalid && bus.rready;
        aw_hs = bus.awvalid && bus.awready;
        w_hs  = bus.wvalid && bus.wready;
        b_hs  = bus.bvalid && bus.bready;
    endtask

    // Presents one request for the accept edge, then scrambles the inputs.
    task automatic start(input bit ld, input bit st, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [7:0] wm, input logic [7:0] rm);
        @(negedge clk);
        drive_mem();
        in_valid = 1; in_load = ld; in_store = st;
        in_addr = addr; in_wdata = wd; in_wmask = wm; in_rmask = rm;
        @(negedge clk);
        in_valid = 0; in_load = 0; in_store = 0;
        in_addr = ~addr; in_wdata = ~wd; in_wmask = 8'h5a; in_rmask = 8'ha5;
    endtask

    // Returns the cycle (1 = first cycle after accept) at which out_valid is seen, 0 on timeout.
    task automatic run_to_done(output int n);
        n = 0; saw_ar = 0; ar_seen = 0; wd_seen = 0; ws_seen = 0;
        for (int k = 0; k < 64; k++) begin awv[k] = 0; wv[k] = 0; end
        for (int i = 1; i < 60; i++) begin
            if (i > 1) @(negedge clk);
            drive_mem();
            if (bus.arvalid && !saw_ar) begin saw_ar = 1; ar_seen = bus.araddr; end
            awv[i] = bus.awvalid;
            wv[i]  = bus.wvalid;
            if (bus.wvalid) begin wd_seen = bus.wdata; ws_seen = bus.wstrb; end
            if (out_valid) begin n = i; break; end
        end
    endtask

    task automatic finish_txn(input string tag);
        out_ready = 1;
        @(negedge clk);
        drive_mem();
        out_ready = 0;
        check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1; in_valid = 0; in_load = 0; in_store = 0;
        in_addr = 0; in_wdata = 0; in_wmask = 0; in_rmask = 0; out_ready = 0;
        r_val = 0; r_resp = 0; b_resp = 0;
        set_waits(0, 0, 0, 0, 0);
        mem_reset();
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_arvalid", 32'(bus.arvalid), 32'd0);
        check("rst_araddr", bus.araddr, 32'h0);
        check("rst_wstrb", 32'(bus.wstrb), 32'h0);
        check("rst_out_rdata", out_rdata, 32'h0);
        @(negedge clk);
        rst = 0;

        // word load, zero waits
        r_val = 32'hDEADBEEF; r_resp = 0;
        start(1, 0, 32'h80000004, 0, 0, 8'hff);
        run_to_done(n);
        check("wl_cycle", n, 3);
        check("wl_araddr", ar_seen, 32'h80000004);
        check("wl_rdata", out_rdata, 32'hDEADBEEF);
        check("wl_err", 32'(out_err), 32'd0);
        finish_txn("wl");

        // byte load from lane 3
        r_val = 32'hA1B2C3D4;
        start(1, 0, 32'h80000003, 0, 0, 8'h01);
        run_to_done(n);
        check("bl_araddr", ar_seen, 32'h80000000);
        check("bl_rdata", out_rdata, 32'h000000A1);
        finish_txn("bl");

        // half load from lane 2, with one wait on arready and on rvalid
        set_waits(1, 1, 0, 0, 0);
        start(1, 0, 32'h80000002, 0, 0, 8'h02);
        run_to_done(n);
        check("hl_cycle", n, 5);
        check("hl_rdata", out_rdata, 32'h0000A1B2);
        finish_txn("hl");

        // byte store to lane 1, awready two cycles late
        set_waits(0, 0, 2, 0, 0); b_resp = 0;
        start(0, 1, 32'h80000001, 32'h000000EE, 8'h02, 0);
        run_to_done(n);
        check("bs_cycle", n, 5);
        check("bs_wdata", wd_seen, 32'h0000EE00);
        check("bs_wstrb", 32'(ws_seen), 32'h2);
        check("bs_wvalid_c1", 32'(wv[1]), 32'd1);
        check("bs_wvalid_c2", 32'(wv[2]), 32'd0);
        check("bs_awvalid_c3", 32'(awv[3]), 32'd1);
        check("bs_awvalid_c4", 32'(awv[4]), 32'd0);
        check("bs_err", 32'(out_err), 32'd0);
        check("bs_rdata", out_rdata, 32'h0);
        finish_txn("bs");

        // misaligned word load: no bus traffic
        set_waits(0, 0, 0, 0, 0);
        start(1, 0, 32'h80000002, 0, 0, 8'hff);
        run_to_done(n);
        check("mis_cycle", n, 1);
        check("mis_err", 32'(out_err), 32'd1);
        check("mis_no_ar", 32'(saw_ar), 32'd0);
        finish_txn("mis");

        // store mask on the wrong lane
        start(0, 1, 32'h80000001, 32'h11, 8'h01, 0);
        run_to_done(n);
        check("lane_cycle", n, 1);
        check("lane_err", 32'(out_err), 32'd1);
        finish_txn("lane");

        // load and store both set
        start(1, 1, 32'h80000000, 0, 8'hff, 8'hff);
        run_to_done(n);
        check("both_err", 32'(out_err), 32'd1);
        finish_txn("both");

        // non-memory instruction
        start(0, 0, 32'h80000003, 0, 0, 0);
        run_to_done(n);
        check("nop_cycle", n, 1);
        check("nop_err", 32'(out_err), 32'd0);
        finish_txn("nop");

        // legal word store with error response, then backpressure in DONE
        b_resp = 2'b10;
        start(0, 1, 32'h80000008, 32'hCAFEF00D, 8'hff, 0);
        run_to_done(n);
        check("ws_cycle", n, 3);
        check("ws_wdata", wd_seen, 32'hCAFEF00D);
        check("ws_wstrb", 32'(ws_seen), 32'hf);
        check("ws_err", 32'(out_err), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_mem();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_err", 32'(out_err), 32'd1);
            check("bp_rdata", out_rdata, 32'h0);
        end
        finish_txn("bp");
        b_resp = 0;

        // load with nonzero read response
        r_val = 32'h0000_0055; r_resp = 2'b11;
        start(1, 0, 32'h80000000, 0, 0, 8'h01);
        run_to_done(n);
        check("rresp_err", 32'(out_err), 32'd1);
        check("rresp_rdata", out_rdata, 32'h55);
        finish_txn("rresp");
        r_resp = 0;

        // reset while waiting in R
        set_waits(0, 3, 0, 0, 0);
        r_val = 32'h99999999;
        start(1, 0, 32'h80000010, 0, 0, 8'hff);
        drive_mem();
        @(negedge clk);
        drive_mem();
        check("mid_rready", 32'(bus.rready), 32'd1);
        #2 rst = 1;
        #1;
        check("mid_rst_rready", 32'(bus.rready), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 0;
        mem_reset();
        set_waits(0, 0, 0, 0, 0);
        r_val = 32'h12345678;
        start(1, 0, 32'h80000000, 0, 0, 8'hff);
        run_to_done(n);
        check("post_rst_cycle", n, 3);
        check("post_rst_rdata", out_rdata, 32'h12345678);
        check("post_rst_err", 32'(out_err), 32'd0);
        finish_txn("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
